// File: rtl/imsic_file_engine.sv
// IMSIC interrupt-file engine: eip/eie bitmaps, eidelivery, eithreshold per
// file, MSI set-pending, indirect CSR access and a word-serial topei scanner.
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_msi_valid/o_msi_ready          MSI set-pending handshake
//   i_msi_file, i_msi_id             MSI target file and identity
//   i_csr_valid/we/file/addr/wdata   indirect CSR request
//   o_csr_rvalid/rdata/exc           CSR response, one cycle after request
//   i_claim, i_claim_file            claim of the current topei of a file
//   o_topei                          per-file top identity, SW bits each
//   o_eip                            per-file interrupt line
module imsic_file_engine #(
    parameter int NR_FILES = 3,
    parameter int NR_SRC   = 64,
    parameter int XLEN     = 64,
    localparam int SW      = $clog2(NR_SRC),
    localparam int FW      = (NR_FILES > 1) ? $clog2(NR_FILES) : 1,
    localparam int NR_REG  = NR_SRC / 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_msi_valid,
    output logic                   o_msi_ready,
    input  logic [FW-1:0]          i_msi_file,
    input  logic [SW-1:0]          i_msi_id,
    input  logic                   i_csr_valid,
    input  logic                   i_csr_we,
    input  logic [FW-1:0]          i_csr_file,
    input  logic [7:0]             i_csr_addr,
    input  logic [XLEN-1:0]        i_csr_wdata,
    output logic                   o_csr_rvalid,
    output logic [XLEN-1:0]        o_csr_rdata,
    output logic                   o_csr_exc,
    input  logic                   i_claim,
    input  logic [FW-1:0]          i_claim_file,
    output logic [NR_FILES*SW-1:0] o_topei,
    output logic [NR_FILES-1:0]    o_eip
);

    localparam int WW = (NR_REG > 1) ? $clog2(NR_REG) : 1;

    logic [NR_REG-1:0][31:0] eip_q [NR_FILES];
    logic [NR_REG-1:0][31:0] eip_d [NR_FILES];
    logic [NR_REG-1:0][31:0] eie_q [NR_FILES];
    logic [NR_REG-1:0][31:0] eie_d [NR_FILES];
    logic [NR_FILES-1:0]     edel_q, edel_d;
    logic [SW-1:0]           ethr_q [NR_FILES];
    logic [SW-1:0]           ethr_d [NR_FILES];
    logic [SW-1:0]           cand_q [NR_FILES];
    logic [SW-1:0]           cand_d [NR_FILES];
    logic [SW-1:0]           topei_q [NR_FILES];
    logic [SW-1:0]           topei_d [NR_FILES];
    logic [NR_FILES-1:0]     stale_q, stale_d;
    logic [NR_FILES-1:0]     eipo_q, eipo_d;
    logic [WW-1:0]           w_q, w_d;
    logic                    rvalid_q;
    logic [XLEN-1:0]         rdata_q;
    logic                    exc_q;

    logic                    commit;
    logic [SW-1:0]           base;
    logic [5:0]              k;
    logic                    is_del, is_thr, is_eip, is_eie, is_map;
    logic                    file_ok, csr_bad, csr_wr, msi_fire;
    logic [31:0]             rd_lo, rd_hi, wlo, whi;
    logic [63:0]             rd64, wd64;
    logic                    rd_del;
    logic [SW-1:0]           rd_thr;
    logic [XLEN-1:0]         csr_rd;

    // CSR decode; the eip region of the MSI file blocks MSIs for a cycle
    // so a CSR bitmap write never races a set-pending on the same word.
    always_comb begin
        k       = i_csr_addr[5:0];
        is_del  = i_csr_addr == 8'h70;
        is_thr  = i_csr_addr == 8'h72;
        is_eip  = i_csr_addr[7:6] == 2'b10;
        is_eie  = i_csr_addr[7:6] == 2'b11;
        is_map  = is_eip | is_eie;
        file_ok = 32'(i_csr_file) < 32'(NR_FILES);
        csr_bad = !file_ok || !(is_del || is_thr || is_map)
                  || (is_map && XLEN == 64 && k[0]);
        csr_wr  = i_csr_valid && i_csr_we && !csr_bad;
        o_msi_ready = !(i_csr_valid && i_csr_we && is_eip
                        && i_csr_file == i_msi_file);
        msi_fire = i_msi_valid && o_msi_ready;
        wd64    = 64'(i_csr_wdata);
        wlo     = wd64[31:0];
        whi     = wd64[63:32];
        rd_lo   = '0;
        rd_hi   = '0;
        rd_del  = 1'b0;
        rd_thr  = '0;
        for (int f = 0; f < NR_FILES; f++) begin
            if (FW'(f) == i_csr_file) begin
                rd_del = edel_q[f];
                rd_thr = ethr_q[f];
                for (int r = 0; r < NR_REG; r++) begin
                    if (k == 6'(r))
                        rd_lo = is_eip ? eip_q[f][r] : eie_q[f][r];
                    if (k + 6'd1 == 6'(r))
                        rd_hi = is_eip ? eip_q[f][r] : eie_q[f][r];
                end
            end
        end
        rd64 = '0;
        if (is_del)
            rd64 = 64'(rd_del);
        else if (is_thr)
            rd64 = 64'(rd_thr);
        else if (is_map)
            rd64 = {rd_hi, rd_lo};
        csr_rd = rd64[XLEN-1:0];
    end

    // State update and scanner.
    always_comb begin
        logic [31:0] word;
        logic        found;
        logic [SW-1:0] fid;
        logic [SW-1:0] cn;
        logic        ev;
        logic        clm;
        commit = w_q == WW'(NR_REG - 1);
        w_d    = commit ? '0 : w_q + WW'(1);
        base   = SW'(w_q) << 5;
        edel_d = edel_q;
        for (int f = 0; f < NR_FILES; f++) begin
            eip_d[f]  = eip_q[f];
            eie_d[f]  = eie_q[f];
            ethr_d[f] = ethr_q[f];
            eipo_d[f] = edel_q[f] && (topei_q[f] != '0);
            clm = i_claim && FW'(f) == i_claim_file;
            ev  = clm || (msi_fire && FW'(f) == i_msi_file);
            if (csr_wr && FW'(f) == i_csr_file) begin
                if (is_map || is_thr)
                    ev = 1'b1;
                if (is_del)
                    edel_d[f] = wlo[0];
                if (is_thr)
                    ethr_d[f] = wlo[SW-1:0];
                for (int r = 0; r < NR_REG; r++) begin
                    if (k == 6'(r)) begin
                        if (is_eip) eip_d[f][r] = wlo;
                        else if (is_eie) eie_d[f][r] = wlo;
                    end
                    if (XLEN == 64 && k + 6'd1 == 6'(r)) begin
                        if (is_eip) eip_d[f][r] = whi;
                        else if (is_eie) eie_d[f][r] = whi;
                    end
                end
            end
            // Claim clears first so a same-cycle MSI on that bit wins.
            for (int r = 0; r < NR_REG; r++) begin
                if (clm && topei_q[f] != '0 && (topei_q[f] >> 5) == SW'(r))
                    eip_d[f][r][topei_q[f][4:0]] = 1'b0;
                if (msi_fire && FW'(f) == i_msi_file
                    && (i_msi_id >> 5) == SW'(r))
                    eip_d[f][r][i_msi_id[4:0]] = 1'b1;
            end
            eip_d[f][0][0] = 1'b0;
            eie_d[f][0][0] = 1'b0;

            word  = eip_q[f][w_q] & eie_q[f][w_q];
            found = 1'b0;
            fid   = '0;
            for (int b = 31; b >= 0; b--) begin
                if (word[b] && (ethr_q[f] == '0
                    || base + SW'(b) < ethr_q[f])) begin
                    found = 1'b1;
                    fid   = base + SW'(b);
                end
            end
            cn = (found && (cand_q[f] == '0 || fid < cand_q[f]))
                 ? fid : cand_q[f];

            // An event in the commit cycle also makes that sweep stale.
            topei_d[f] = topei_q[f];
            if (clm)
                topei_d[f] = '0;
            else if (commit && !(stale_q[f] || ev))
                topei_d[f] = cn;
            cand_d[f]  = commit ? '0 : cn;
            stale_d[f] = commit ? 1'b0 : (stale_q[f] || ev);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            eip_q    <= '{default: '0};
            eie_q    <= '{default: '0};
            ethr_q   <= '{default: '0};
            cand_q   <= '{default: '0};
            topei_q  <= '{default: '0};
            edel_q   <= '0;
            stale_q  <= '0;
            eipo_q   <= '0;
            w_q      <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            exc_q    <= 1'b0;
        end else begin
            eip_q    <= eip_d;
            eie_q    <= eie_d;
            ethr_q   <= ethr_d;
            cand_q   <= cand_d;
            topei_q  <= topei_d;
            edel_q   <= edel_d;
            stale_q  <= stale_d;
            eipo_q   <= eipo_d;
            w_q      <= w_d;
            rvalid_q <= i_csr_valid;
            rdata_q  <= (i_csr_valid && !csr_bad) ? csr_rd : '0;
            exc_q    <= i_csr_valid && csr_bad;
        end
    end

    always_comb begin
        for (int f = 0; f < NR_FILES; f++)
            o_topei[f*SW +: SW] = topei_q[f];
    end

    assign o_eip        = eipo_q;
    assign o_csr_rvalid = rvalid_q;
    assign o_csr_rdata  = rdata_q;
    assign o_csr_exc    = exc_q;

endmodule

// File: tb/tb_imsic_file_engine.sv
// Directed bench for imsic_file_engine: CSR vector table plus hand-written
// topei, threshold, claim and MSI/CSR collision sequences.
module tb_imsic_file_engine;

    localparam int NF = 3;
    localparam int NS = 64;
    localparam int XL = 64;
    localparam int SW = 6;
    localparam int FW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          msi_valid;
    logic          msi_ready;
    logic [FW-1:0] msi_file;
    logic [SW-1:0] msi_id;
    logic          csr_valid;
    logic          csr_we;
    logic [FW-1:0] csr_file;
    logic [7:0]    csr_addr;
    logic [XL-1:0] csr_wdata;
    logic          csr_rvalid;
    logic [XL-1:0] csr_rdata;
    logic          csr_exc;
    logic          claim;
    logic [FW-1:0] claim_file;
    logic [NF*SW-1:0] topei;
    logic [NF-1:0] eip;

    int total = 0;
    int bad   = 0;

    imsic_file_engine #(.NR_FILES(NF), .NR_SRC(NS), .XLEN(XL)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_msi_valid(msi_valid), .o_msi_ready(msi_ready),
        .i_msi_file(msi_file), .i_msi_id(msi_id),
        .i_csr_valid(csr_valid), .i_csr_we(csr_we),
        .i_csr_file(csr_file), .i_csr_addr(csr_addr),
        .i_csr_wdata(csr_wdata), .o_csr_rvalid(csr_rvalid),
        .o_csr_rdata(csr_rdata), .o_csr_exc(csr_exc),
        .i_claim(claim), .i_claim_file(claim_file),
        .o_topei(topei), .o_eip(eip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  file;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
        logic        exp_exc;
    } vec_t;

    vec_t tbl[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] tp(input int f);
        return topei[f*SW +: SW];
    endfunction

    task automatic add(input logic we, input logic [1:0] f,
                       input logic [7:0] a, input logic [63:0] wd,
                       input logic [63:0] rd, input logic ex);
        vec_t v;
        v.we = we; v.file = f; v.addr = a; v.wdata = wd;
        v.exp_rd = rd; v.exp_exc = ex;
        tbl.push_back(v);
    endtask

    task automatic csr_op(input logic we, input logic [1:0] f,
                          input logic [7:0] a, input logic [63:0] wd);
        csr_valid = 1'b1; csr_we = we; csr_file = f;
        csr_addr = a; csr_wdata = wd;
        cyc();
        csr_valid = 1'b0; csr_we = 1'b0;
    endtask

    task automatic csr_rd(input string name, input logic [1:0] f,
                          input logic [7:0] a, input logic [63:0] exp);
        csr_op(1'b0, f, a, '0);
        chk(name, csr_rdata, exp);
    endtask

    task automatic msi(input logic [1:0] f, input logic [SW-1:0] id);
        msi_valid = 1'b1; msi_file = f; msi_id = id;
        cyc();
        msi_valid = 1'b0;
    endtask

    // Waits up to 2*NR_REG+1 edges for the file's topei to reach exp.
    task automatic wait_tp(input string name, input int f,
                           input logic [SW-1:0] exp);
        for (int n = 0; n < 5; n++) begin
            if (tp(f) == exp) break;
            cyc();
        end
        chk(name, 64'(tp(f)), 64'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; msi_valid = 1'b0; msi_file = '0; msi_id = '0;
        csr_valid = 1'b0; csr_we = 1'b0; csr_file = '0;
        csr_addr = '0; csr_wdata = '0; claim = 1'b0; claim_file = '0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_topei", 64'(topei), 64'd0);
        chk("rst_eip", 64'(eip), 64'd0);
        chk("rst_rvalid", 64'(csr_rvalid), 64'd0);
        chk("rst_rdata", csr_rdata, 64'd0);
        chk("rst_exc", 64'(csr_exc), 64'd0);
        chk("rst_ready", 64'(msi_ready), 64'd1);

        for (int f = 0; f < NF; f++) begin
            add(0, 2'(f), 8'h70, 0, 0, 0);
            add(0, 2'(f), 8'h72, 0, 0, 0);
            add(0, 2'(f), 8'h80, 0, 0, 0);
            add(0, 2'(f), 8'hC0, 0, 0, 0);
        end
        add(0, 2'd3, 8'h70, 0, 0, 1);
        add(0, 2'd0, 8'h81, 0, 0, 1);
        add(0, 2'd0, 8'h71, 0, 0, 1);
        add(0, 2'd0, 8'h00, 0, 0, 1);
        add(0, 2'd1, 8'h84, 0, 0, 0);
        add(1, 2'd1, 8'h84, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        add(0, 2'd1, 8'h80, 0, 0, 0);
        add(1, 2'd0, 8'hC1, 64'hFF, 0, 1);
        add(1, 2'd3, 8'h80, 64'hFF, 0, 1);
        add(0, 2'd0, 8'hC0, 0, 0, 0);
        add(1, 2'd2, 8'h70, 64'hFF, 0, 0);
        add(0, 2'd2, 8'h70, 0, 64'h1, 0);
        add(1, 2'd2, 8'h72, 64'hFFF, 0, 0);
        add(0, 2'd2, 8'h72, 0, 64'h3F, 0);
        add(1, 2'd2, 8'h72, 64'h0, 0, 0);
        add(0, 2'd2, 8'h72, 0, 64'h0, 0);

        foreach (tbl[i]) begin
            csr_op(tbl[i].we, tbl[i].file, tbl[i].addr, tbl[i].wdata);
            chk($sformatf("vec%0d_rvalid", i), 64'(csr_rvalid), 64'd1);
            chk($sformatf("vec%0d_exc", i), 64'(csr_exc),
                64'(tbl[i].exp_exc));
            if (!tbl[i].we)
                chk($sformatf("vec%0d_rdata", i), csr_rdata, tbl[i].exp_rd);
        end
        cyc();
        chk("rvalid_drop", 64'(csr_rvalid), 64'd0);

        csr_op(1'b1, 2'd1, 8'h70, 64'h1);
        csr_op(1'b1, 2'd1, 8'hC0, 64'h0000_0000_FFFF_FFFE);
        msi(2'd1, 6'd9);
        msi(2'd1, 6'd5);
        wait_tp("topei1_5", 1, 6'd5);
        cyc();
        chk("eip_line1", 64'(eip), 64'b010);
        chk("topei0_idle", 64'(tp(0)), 64'd0);
        chk("topei2_idle", 64'(tp(2)), 64'd0);

        csr_op(1'b1, 2'd1, 8'h72, 64'd5);
        repeat (4) cyc();
        chk("thr5", 64'(tp(1)), 64'd0);
        csr_op(1'b1, 2'd1, 8'h72, 64'd10);
        wait_tp("thr10", 1, 6'd5);

        claim = 1'b1; claim_file = 2'd1;
        cyc();
        claim = 1'b0;
        chk("claim_zero", 64'(tp(1)), 64'd0);
        wait_tp("claim_next9", 1, 6'd9);
        csr_rd("eip1_after_claim", 2'd1, 8'h80, 64'h200);

        csr_valid = 1'b1; csr_we = 1'b1; csr_file = 2'd0;
        csr_addr = 8'h80; csr_wdata = 64'h0000_0001_0000_0011;
        msi_valid = 1'b1; msi_file = 2'd0; msi_id = 6'd3;
        #1;
        chk("ready_blocked", 64'(msi_ready), 64'd0);
        cyc();
        csr_valid = 1'b0; csr_we = 1'b0;
        #1;
        chk("ready_back", 64'(msi_ready), 64'd1);
        cyc();
        msi_valid = 1'b0;
        csr_rd("eip0_merge", 2'd0, 8'h80, 64'h0000_0001_0000_0018);

        claim = 1'b1; claim_file = 2'd1;
        msi_valid = 1'b1; msi_file = 2'd1; msi_id = 6'd9;
        cyc();
        claim = 1'b0; msi_valid = 1'b0;
        chk("claim_msi_zero", 64'(tp(1)), 64'd0);
        wait_tp("claim_msi_back9", 1, 6'd9);
        csr_rd("eip1_setwins", 2'd1, 8'h80, 64'h200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
